// File: rtl/xm23_alu.sv
// XM23 datapath ALU: arithmetic, BCD, logic, shift and extend ops with PSW flag update.
// Result and PSW are registered, so latency is one clock and throughput is one op per clock.
module xm23_alu (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] dst,
    input  logic [15:0] src,
    input  logic [5:0]  alu_op,
    input  logic [15:0] psw_in,
    input  logic        psw_update,
    output logic [15:0] alu_out,
    output logic [15:0] psw_out
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_ADDC = 5'd1,
        OP_SUB  = 5'd2,
        OP_SUBC = 5'd3,
        OP_DADD = 5'd4,
        OP_CMP  = 5'd5,
        OP_XOR  = 5'd6,
        OP_AND  = 5'd7,
        OP_OR   = 5'd8,
        OP_BIT  = 5'd9,
        OP_BIC  = 5'd10,
        OP_BIS  = 5'd11,
        OP_MOV  = 5'd12,
        OP_SWAP = 5'd13,
        OP_SRA  = 5'd14,
        OP_RRC  = 5'd15,
        OP_SWPB = 5'd16,
        OP_SXT  = 5'd17
    } op_e;

    localparam int PSW_C = 0;
    localparam int PSW_Z = 1;
    localparam int PSW_N = 2;
    localparam int PSW_V = 4;

    // In byte mode the upper byte of the result is always the destination's upper byte.
    function automatic logic [15:0] merge_byte(input logic bm, input logic [15:0] d,
                                               input logic [15:0] w);
        return bm ? {d[15:8], w[7:0]} : w;
    endfunction

    logic [4:0]  op;
    logic        byte_mode;
    logic        c_in;
    logic        sub_op;
    logic [15:0] b_opnd;
    logic        add_cin;
    logic [16:0] sum_w;
    logic [8:0]  sum_b;
    logic [15:0] arith_res;
    logic        arith_c;
    logic        arith_v;
    logic [15:0] bcd_res;
    logic        bcd_c;
    logic [15:0] res;
    logic [15:0] fres;
    logic        new_c;
    logic        new_v;
    logic        upd_c;
    logic        upd_zn;
    logic        upd_v;
    logic        flag_z;
    logic        flag_n;
    logic [15:0] alu_d, alu_q;
    logic [15:0] psw_d, psw_q;

    assign op        = alu_op[4:0];
    assign byte_mode = alu_op[5] && (op != OP_SWPB) && (op != OP_SXT);
    assign c_in      = psw_in[PSW_C];
    assign sub_op    = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
    assign b_opnd    = sub_op ? ~src : src;
    assign add_cin   = ((op == OP_ADDC) || (op == OP_SUBC)) ? c_in : sub_op;

    assign sum_w = {1'b0, dst} + {1'b0, b_opnd} + {16'b0, add_cin};
    assign sum_b = {1'b0, dst[7:0]} + {1'b0, b_opnd[7:0]} + {8'b0, add_cin};

    assign arith_res = byte_mode ? {dst[15:8], sum_b[7:0]} : sum_w[15:0];
    assign arith_c   = byte_mode ? sum_b[8] : sum_w[16];
    assign arith_v   = byte_mode
                     ? ((dst[7]  == b_opnd[7])  && (arith_res[7]  != dst[7]))
                     : ((dst[15] == b_opnd[15]) && (arith_res[15] != dst[15]));

    // Decimal add: each nibble above 9 wraps by ten and carries into the next nibble.
    always_comb begin
        logic [4:0] nib_sum;
        // NOTE: blocking assignments are correct here; the carry must ripple through the loop.
        bcd_res = dst;
        bcd_c   = c_in;
        nib_sum = 5'd0;
        for (int i = 0; i < 4; i++) begin
            if (!byte_mode || (i < 2)) begin
                nib_sum = {1'b0, dst[4*i +: 4]} + {1'b0, src[4*i +: 4]} + {4'b0, bcd_c};
                if (nib_sum > 5'd9) begin
                    nib_sum = nib_sum - 5'd10;
                    bcd_c   = 1'b1;
                end else begin
                    bcd_c   = 1'b0;
                end
                bcd_res[4*i +: 4] = nib_sum[3:0];
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        res    = dst;
        fres   = dst;
        new_c  = psw_in[PSW_C];
        new_v  = psw_in[PSW_V];
        upd_c  = 1'b0;
        upd_zn = 1'b0;
        upd_v  = 1'b0;
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                res    = arith_res;
                fres   = arith_res;
                new_c  = arith_c;
                new_v  = arith_v;
                upd_c  = 1'b1;
                upd_zn = 1'b1;
                upd_v  = 1'b1;
            end
            OP_CMP: begin
                fres   = arith_res;
                new_c  = arith_c;
                new_v  = arith_v;
                upd_c  = 1'b1;
                upd_zn = 1'b1;
                upd_v  = 1'b1;
            end
            OP_DADD: begin
                res    = bcd_res;
                fres   = bcd_res;
                new_c  = bcd_c;
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_XOR, OP_AND, OP_OR, OP_BIC, OP_BIS: begin
                case (op)
                    OP_XOR:  res = merge_byte(byte_mode, dst, dst ^ src);
                    OP_AND:  res = merge_byte(byte_mode, dst, dst & src);
                    OP_OR:   res = merge_byte(byte_mode, dst, dst | src);
                    OP_BIC:  res = merge_byte(byte_mode, dst, dst & ~src);
                    default: res = merge_byte(byte_mode, dst, dst | src);
                endcase
                fres   = res;
                upd_zn = 1'b1;
            end
            OP_BIT: begin
                fres   = dst & src;
                upd_zn = 1'b1;
            end
            OP_MOV, OP_SWAP: begin
                res = merge_byte(byte_mode, dst, src);
            end
            OP_SRA, OP_RRC: begin
                if (byte_mode) begin
                    res = {dst[15:8], (op == OP_SRA) ? dst[7] : c_in, dst[7:1]};
                end else begin
                    res = {(op == OP_SRA) ? dst[15] : c_in, dst[15:1]};
                end
                fres   = res;
                new_c  = dst[0];
                upd_c  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_SWPB: begin
                res    = {dst[7:0], dst[15:8]};
                fres   = res;
                upd_zn = 1'b1;
            end
            OP_SXT: begin
                res    = {{8{dst[7]}}, dst[7:0]};
                fres   = res;
                upd_zn = 1'b1;
            end
            default: begin
                res = dst;
            end
        endcase
    end

    assign flag_z = byte_mode ? (fres[7:0] == 8'h00) : (fres == 16'h0000);
    assign flag_n = byte_mode ? fres[7] : fres[15];

    always_comb begin
        psw_d = psw_in;
        if (psw_update) begin
            if (upd_c) begin
                psw_d[PSW_C] = new_c;
            end
            if (upd_zn) begin
                psw_d[PSW_Z] = flag_z;
                psw_d[PSW_N] = flag_n;
            end
            if (upd_v) begin
                psw_d[PSW_V] = new_v;
            end
        end
    end

    assign alu_d = res;

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            alu_q <= 16'h0000;
            psw_q <= 16'h0000;
        end else begin
            alu_q <= alu_d;
            psw_q <= psw_d;
        end
    end

    assign alu_out = alu_q;
    assign psw_out = psw_q;

endmodule

// File: tb/tb_xm23_alu.sv
// Directed-vector bench for xm23_alu; expected results are hand-computed constants.
// Inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
module tb_xm23_alu;

    logic        Clock;
    logic        Reset;
    logic [15:0] dst;
    logic [15:0] src;
    logic [5:0]  alu_op;
    logic [15:0] psw_in;
    logic        psw_update;
    logic [15:0] alu_out;
    logic [15:0] psw_out;

    int tests_run;
    int tests_failed;

    xm23_alu dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .dst        (dst),
        .src        (src),
        .alu_op     (alu_op),
        .psw_in     (psw_in),
        .psw_update (psw_update),
        .alu_out    (alu_out),
        .psw_out    (psw_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Apply one op, clock it, then compare both registered outputs.
    task automatic run_op(input string tag, input logic [4:0] op, input logic bm,
                          input logic [15:0] d, input logic [15:0] s,
                          input logic [15:0] psw, input logic upd,
                          input logic [15:0] exp_out, input logic [15:0] exp_psw);
        @(negedge Clock);
        Reset      = 1'b0;
        dst        = d;
        src        = s;
        alu_op     = {bm, op};
        psw_in     = psw;
        psw_update = upd;
        @(posedge Clock);
        #1;
        check({tag, ".out"}, alu_out, exp_out);
        check({tag, ".psw"}, psw_out, exp_psw);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset        = 1'b1;
        dst          = 16'h1234;
        src          = 16'h5678;
        alu_op       = 6'd0;
        psw_in       = 16'hFFFF;
        psw_update   = 1'b1;
        @(posedge Clock);
        #1;
        check("reset.out", alu_out, 16'h0000);
        check("reset.psw", psw_out, 16'h0000);

        //      tag          op     bm    dst       src       psw_in    upd   alu_out   psw_out
        run_op("add_w",     5'd0,  1'b0, 16'h7FFF, 16'h0001, 16'h60E0, 1'b1, 16'h8000, 16'h60F4);
        run_op("add_b",     5'd0,  1'b1, 16'h12FF, 16'h0001, 16'h0000, 1'b1, 16'h1200, 16'h0003);
        run_op("addc_w",    5'd1,  1'b0, 16'h0001, 16'h0001, 16'h0001, 1'b1, 16'h0003, 16'h0000);
        run_op("sub_w",     5'd2,  1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 16'h0000, 16'h0003);
        run_op("subc_b",    5'd3,  1'b1, 16'h0080, 16'h0001, 16'h0001, 1'b1, 16'h007F, 16'h0011);
        run_op("cmp_w",     5'd5,  1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 16'h0005, 16'h0003);
        run_op("dadd_w1",   5'd4,  1'b0, 16'h0199, 16'h0001, 16'h0010, 1'b1, 16'h0200, 16'h0010);
        run_op("dadd_w2",   5'd4,  1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 16'h0000, 16'h0003);
        run_op("dadd_b",    5'd4,  1'b1, 16'hAA58, 16'h0047, 16'h0001, 1'b1, 16'hAA06, 16'h0001);
        run_op("xor_b",     5'd6,  1'b1, 16'hAB0F, 16'h00F0, 16'h0013, 1'b1, 16'hABFF, 16'h0015);
        run_op("bit_w",     5'd9,  1'b0, 16'h00F0, 16'h000F, 16'h0000, 1'b1, 16'h00F0, 16'h0002);
        run_op("bic_w",     5'd10, 1'b0, 16'hFFFF, 16'h00FF, 16'h0000, 1'b1, 16'hFF00, 16'h0004);
        run_op("mov_w",     5'd12, 1'b0, 16'h1111, 16'h5555, 16'h001F, 1'b1, 16'h5555, 16'h001F);
        run_op("rrc_w",     5'd15, 1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b1, 16'h8000, 16'h0005);
        run_op("rrc_b",     5'd15, 1'b1, 16'h1203, 16'h0000, 16'h0000, 1'b1, 16'h1201, 16'h0001);
        run_op("sra_w",     5'd14, 1'b0, 16'h8002, 16'h0000, 16'h0000, 1'b1, 16'hC001, 16'h0004);
        run_op("swpb",      5'd16, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b1, 16'h3412, 16'h0000);
        run_op("sxt_bsel",  5'd17, 1'b1, 16'h1280, 16'h0000, 16'h0000, 1'b1, 16'hFF80, 16'h0004);
        run_op("add_noupd", 5'd0,  1'b0, 16'hFFFF, 16'h0001, 16'hABCD, 1'b0, 16'h0000, 16'hABCD);
        run_op("undef31",   5'd31, 1'b0, 16'h1234, 16'h4321, 16'h5A5A, 1'b1, 16'h1234, 16'h5A5A);

        // Reset in the middle of a stream wins over the op presented on that edge.
        @(negedge Clock);
        Reset      = 1'b1;
        dst        = 16'h7FFF;
        src        = 16'h0001;
        alu_op     = 6'd0;
        psw_in     = 16'h60E0;
        psw_update = 1'b1;
        @(posedge Clock);
        #1;
        check("mid_reset.out", alu_out, 16'h0000);
        check("mid_reset.psw", psw_out, 16'h0000);

        run_op("post_reset31", 5'd31, 1'b0, 16'hBEEF, 16'h0000, 16'h0007, 1'b1, 16'hBEEF, 16'h0007);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
